// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial adder.
module fa_bit (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic C_OUT
);

    assign S     = A ^ B ^ C;
    assign C_OUT = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB-first shifting.
// Optional macro SERIAL_ADDER_OVF_EN adds a two's-complement overflow output OVF.
import serial_adder_pkg::*;

module serial_adder #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    fa_bit u_fa (
        .A     (a_q[0]),
        .B     (b_q[0]),
        .C     (c_q),
        .S     (fa_s),
        .C_OUT (fa_c)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        count_d  = count_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            // FIN accepts a new request exactly like IDLE so back-to-back adds lose no cycle.
            IDLE, FIN: begin
                if (START) begin
                    a_d      = A;
                    b_d      = B;
                    c_d      = C_IN;
                    count_d  = '0;
                    sum_sr_d = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end

            SHIFT: begin
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                c_d      = fa_c;
                count_d  = count_q + 1'b1;
                busy_d   = 1'b1;
                if (count_q == LAST) begin
                    sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    c_out_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB on this final bit.
                    ovf_d   = c_q ^ fa_c;
`endif
                    count_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            count_q  <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            count_q  <= count_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign SUM   = sum_q;
    assign C_OUT = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit instance for the scenarios and a 2-bit instance for the exhaustive sweep.
module tb_serial_adder;

    logic       CLK;
    logic       RST;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2;
    logic [1:0] sum2;
    logic       cout2;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf2;
`endif

    int n_tests;
    int n_fail;

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK   (CLK),
        .RST   (RST),
        .START (start8),
        .A     (a8),
        .B     (b8),
        .C_IN  (cin8),
        .BUSY  (busy8),
        .DONE  (done8),
        .SUM   (sum8),
        .C_OUT (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .CLK   (CLK),
        .RST   (RST),
        .START (start2),
        .A     (a2),
        .B     (b2),
        .C_IN  (cin2),
        .BUSY  (busy2),
        .DONE  (done2),
        .SUM   (sum2),
        .C_OUT (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (ovf2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Presents one request for a single edge; returns at the negedge of the first cycle after acceptance.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge CLK);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = cin;
        @(negedge CLK);
        start8 = 1'b0;
    endtask

    // Advances negedge by negedge until DONE is seen, with a cycle bound.
    task automatic wait_done8(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done8 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy8); end
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done8); end
        n_tests++; if (sum8 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_sum got %h want 00", sum8); end
        n_tests++; if (cout8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cout got %b want 0", cout8); end
        n_tests++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_w2 got busy=%b done=%b want 0 0", busy2, done2); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic;
        int cycles;
        start_op8(8'h5A, 8'h3C, 1'b0);
        cycles = 0;
        while (busy8 === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge CLK);
        end
        n_tests++; if (cycles != 8) begin n_fail++; $display("[TB] FAIL basic_busy_cycles got %0d want 8", cycles); end
        n_tests++; if (done8 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done_when_busy_falls got %b want 1", done8); end
        n_tests++; if (sum8 !== 8'h96) begin n_fail++; $display("[TB] FAIL basic_sum got %h want 96", sum8); end
        n_tests++; if (cout8 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_cout got %b want 0", cout8); end
        @(negedge CLK);
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_done_one_cycle got %b want 0", done8); end
        n_tests++; if (sum8 !== 8'h96) begin n_fail++; $display("[TB] FAIL basic_sum_hold got %h want 96", sum8); end
    endtask

    task automatic test_back_to_back;
        logic seen;
        int   n;
        start_op8(8'hFF, 8'h01, 1'b0);
        wait_done8(seen);
        n_tests++; if (!seen) begin n_fail++; $display("[TB] FAIL b2b_first_done got timeout want DONE"); end
        n_tests++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_result got %h/%b want 00/1", sum8, cout8); end
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        cin8   = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            start8 = 1'b0;
            n++;
        end while (done8 !== 1'b1 && n < 30);
        n_tests++; if (n != 9) begin n_fail++; $display("[TB] FAIL b2b_spacing got %0d want 9", n); end
        n_tests++; if (sum8 !== 8'hFF || cout8 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_second_result got %h/%b want ff/1", sum8, cout8); end
        @(negedge CLK);
    endtask

    task automatic test_start_ignored;
        int dones;
        start_op8(8'h11, 8'h22, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start8 = 1'b1;
            a8     = (i % 2 == 0) ? 8'hAA : 8'h55;
            b8     = (i % 2 == 0) ? 8'hAA : 8'h0F;
            cin8   = (i % 2 == 0);
            @(negedge CLK);
        end
        start8 = 1'b0;
        dones  = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 === 1'b1) begin
                dones++;
                n_tests++; if (sum8 !== 8'h33 || cout8 !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_result got %h/%b want 33/0", sum8, cout8); end
            end
            @(negedge CLK);
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("[TB] FAIL ignore_done_count got %0d want 1", dones); end
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_idle_after got busy=%b want 0", busy8); end
    endtask

    task automatic test_reset_abort;
        int   dones;
        logic seen;
        start_op8(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flags got busy=%b done=%b want 0 0", busy8, done8); end
        n_tests++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_result got %h/%b want 00/0", sum8, cout8); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
            @(negedge CLK);
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d activity cycles want 0", dones); end
        start_op8(8'h12, 8'h34, 1'b1);
        wait_done8(seen);
        n_tests++; if (!seen || sum8 !== 8'h47 || cout8 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_recover got seen=%b %h/%b want 1 47/0", seen, sum8, cout8); end
        @(negedge CLK);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        logic seen;
        start_op8(8'h7F, 8'h01, 1'b0);
        wait_done8(seen);
        n_tests++; if (!seen || sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_pos got %h/%b/%b want 80/0/1", sum8, cout8, ovf8); end
        start_op8(8'h80, 8'h80, 1'b0);
        wait_done8(seen);
        n_tests++; if (!seen || sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_neg got %h/%b/%b want 00/1/1", sum8, cout8, ovf8); end
        start_op8(8'hFF, 8'h01, 1'b0);
        wait_done8(seen);
        n_tests++; if (!seen || ovf8 !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_none got %b want 0", ovf8); end
        @(negedge CLK);
    endtask
`endif

    task automatic test_width2_sweep;
        int         n;
        int         r;
        logic [1:0] exp_s;
        logic       exp_c;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    r     = a + b + c;
                    exp_s = r[1:0];
                    exp_c = r[2];
                    start2 = 1'b1;
                    a2     = a[1:0];
                    b2     = b[1:0];
                    cin2   = c[0];
                    n = 0;
                    do begin
                        @(negedge CLK);
                        start2 = 1'b0;
                        n++;
                    end while (done2 !== 1'b1 && n < 10);
                    n_tests++; if (n != 3) begin n_fail++; $display("[TB] FAIL w2_latency a=%0d b=%0d c=%0d got %0d edges want 2", a, b, c, n - 1); end
                    n_tests++; if (sum2 !== exp_s) begin n_fail++; $display("[TB] FAIL w2_sum a=%0d b=%0d c=%0d got %0d want %0d", a, b, c, sum2, exp_s); end
                    n_tests++; if (cout2 !== exp_c) begin n_fail++; $display("[TB] FAIL w2_cout a=%0d b=%0d c=%0d got %b want %b", a, b, c, cout2, exp_c); end
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b1;
        start8  = 1'b0;
        a8      = '0;
        b8      = '0;
        cin8    = 1'b0;
        start2  = 1'b0;
        a2      = '0;
        b2      = '0;
        cin2    = 1'b0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_width2_sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
